// File: rtl/core_sequencer_pkg.sv
// rtl/core_sequencer_pkg.sv - shared states, opcode constants and decode helpers for the sequencer
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam logic [4:0] OP_LW        = 5'b00010;
    localparam logic [4:0] OP_SW        = 5'b00011;
    localparam logic [8:0] INSTR_HALT   = 9'h1FF;
    localparam logic [1:0] CLASS_BRANCH = 2'b11;

    function automatic logic is_load(input logic [8:0] instr);
        return instr[8:4] == OP_LW;
    endfunction

    function automatic logic is_store(input logic [8:0] instr);
        return instr[8:4] == OP_SW;
    endfunction

    // The halt word also carries the branch class bits, so callers test halt first.
    function automatic logic is_branch(input logic [8:0] instr);
        return instr[8:7] == CLASS_BRANCH;
    endfunction

    function automatic logic is_busy(input state_t st);
        return (st == ST_FETCH) || (st == ST_EXEC) || (st == ST_MEM_WAIT);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - control, ROM, decoder and data-memory signals of the sequencer
interface core_sequencer_if #(
    parameter int PCW = 10,
    parameter int W   = 8
);
    logic           Start;
    logic [8:0]     InstrIn;
    logic           BranchUp;
    logic           BranchDown;
    logic [W-1:0]   PCTarget;
    logic [PCW-1:0] PC;
    logic [8:0]     IR;
    logic           RegWrEn;
    logic           MemReq;
    logic           MemWe;
    logic           Busy;
    logic           Done;
    logic [15:0]    CycleCount;

    modport master (
        input  Start, InstrIn, BranchUp, BranchDown, PCTarget,
        output PC, IR, RegWrEn, MemReq, MemWe, Busy, Done, CycleCount
    );

    modport slave (
        output Start, InstrIn, BranchUp, BranchDown, PCTarget,
        input  PC, IR, RegWrEn, MemReq, MemWe, Busy, Done, CycleCount
    );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - fetch/execute sequencer with multi-cycle memory wait and halt
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int PCW     = 10,
    parameter int W       = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    core_sequencer_if.master    bus
);

    localparam int CW = $clog2(MEM_LAT) + 1;

    state_t         state, state_next;
    logic [PCW-1:0] pc, pc_next;
    logic [8:0]     ir, ir_next;
    logic [CW-1:0]  lat_cnt, lat_cnt_next;
    logic [15:0]    cycle_count, cycle_count_next;
    logic           reg_wr_en;
    logic [PCW-1:0] target;

    // Branch distance is unsigned; sums below wrap naturally at PCW bits.
    assign target = PCW'(bus.PCTarget);

    // State and datapath registers; reset wins over everything including a pending memory wait.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            ir          <= '0;
            lat_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            ir          <= ir_next;
            lat_cnt     <= lat_cnt_next;
            cycle_count <= cycle_count_next;
        end
    end

    // Next-state, PC update and register-write strobe, decoded from state and the latched IR only.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        ir_next          = ir;
        lat_cnt_next     = lat_cnt;
        cycle_count_next = cycle_count;
        reg_wr_en        = 1'b0;

        if (is_busy(state) && (cycle_count != 16'hFFFF)) begin
            cycle_count_next = cycle_count + 16'd1;
        end

        case (state)
            ST_IDLE: begin
                pc_next = '0;
                if (bus.Start) begin
                    state_next       = ST_FETCH;
                    cycle_count_next = '0;
                end
            end
            ST_FETCH: begin
                ir_next    = bus.InstrIn;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (ir == INSTR_HALT) begin
                    state_next = ST_HALT;
                end else if (is_load(ir) || is_store(ir)) begin
                    state_next   = ST_MEM_WAIT;
                    lat_cnt_next = CW'(MEM_LAT - 1);
                end else if (is_branch(ir)) begin
                    state_next = ST_FETCH;
                    if (bus.BranchDown) begin
                        pc_next = pc + target;
                    end else if (bus.BranchUp) begin
                        pc_next = pc - target;
                    end else begin
                        pc_next = pc + PCW'(1);
                    end
                end else begin
                    reg_wr_en  = 1'b1;
                    pc_next    = pc + PCW'(1);
                    state_next = ST_FETCH;
                end
            end
            ST_MEM_WAIT: begin
                if (lat_cnt == '0) begin
                    reg_wr_en  = is_load(ir);
                    pc_next    = pc + PCW'(1);
                    state_next = ST_FETCH;
                end else begin
                    lat_cnt_next = lat_cnt - CW'(1);
                end
            end
            ST_HALT: begin
                if (bus.Start) begin
                    pc_next          = '0;
                    cycle_count_next = '0;
                    state_next       = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.PC         = pc;
    assign bus.IR         = ir;
    assign bus.RegWrEn    = reg_wr_en;
    assign bus.MemReq     = (state == ST_MEM_WAIT);
    assign bus.MemWe      = (state == ST_MEM_WAIT) && is_store(ir);
    assign bus.Busy       = is_busy(state);
    assign bus.Done       = (state == ST_HALT);
    assign bus.CycleCount = cycle_count;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard bench with an instruction-level reference model
module tb_core_sequencer;

    localparam int PCW     = 10;
    localparam int W       = 8;
    localparam int MEM_LAT = 2;

    typedef struct {
        int       cyc;
        logic [9:0] pc;
        bit       regwr;
        bit       memreq;
        bit       memwe;
        bit       done;
        int       cc;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    core_sequencer_if #(.PCW(PCW), .W(W)) bus();

    core_sequencer #(.PCW(PCW), .W(W), .MEM_LAT(MEM_LAT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [8:0] rom [1024];
    bit         bd_tab [1024];
    bit         bu_tab [1024];
    logic [7:0] tgt_tab [1024];

    assign bus.InstrIn    = rom[bus.PC];
    assign bus.BranchDown = bd_tab[bus.PC];
    assign bus.BranchUp   = bu_tab[bus.PC];
    assign bus.PCTarget   = tgt_tab[bus.PC];

    exp_t sb[$];
    exp_t plan[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_count = 0;
    bit   mon_en = 0;
    int   mcyc = 0;
    bit   prev_busy = 0;
    bit   prev_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every cycle with a strobe or a fresh halt is matched against the next expected event.
    always @(negedge Clk) begin
        if (mon_en) begin
            exp_t e;
            if (bus.Busy && !prev_busy) mcyc = 0;
            else mcyc++;
            prev_busy = bus.Busy;
            if (bus.RegWrEn || bus.MemReq || (bus.Done && !prev_done)) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: cyc=%0d pc=%0d rw=%0b mr=%0b mw=%0b dn=%0b, expected no event",
                             mcyc, bus.PC, bus.RegWrEn, bus.MemReq, bus.MemWe, bus.Done);
                end else begin
                    e = sb.pop_front();
                    if (mcyc != e.cyc || bus.PC !== e.pc || bus.RegWrEn !== e.regwr || bus.MemReq !== e.memreq ||
                        bus.MemWe !== e.memwe || bus.Done !== e.done || int'(bus.CycleCount) != e.cc) begin
                        miscompares++;
                        $display("FAIL event: got cyc=%0d pc=%0d rw=%0b mr=%0b mw=%0b dn=%0b cc=%0d, expected cyc=%0d pc=%0d rw=%0b mr=%0b mw=%0b dn=%0b cc=%0d",
                                 mcyc, bus.PC, bus.RegWrEn, bus.MemReq, bus.MemWe, bus.Done, bus.CycleCount,
                                 e.cyc, e.pc, e.regwr, e.memreq, e.memwe, e.done, e.cc);
                    end
                end
                if (bus.Done && !prev_done) done_count++;
            end
            prev_done = bus.Done;
        end
    end

    // Reference model: walk the program one instruction at a time, cycle 0 being the first fetch.
    task automatic build_plan(input bit use_ovr, input logic [8:0] ovr, output bit ok, output int halt_cyc);
        logic [9:0] cur;
        logic [9:0] nxt;
        logic [8:0] ins;
        int         t;
        plan.delete();
        cur = '0; t = 0; ok = 0; halt_cyc = 0;
        for (int step = 0; step < 150; step++) begin
            ins = (use_ovr && step == 0) ? ovr : rom[cur];
            if (ins == 9'h1FF) begin
                plan.push_back('{cyc:t+2, pc:cur, regwr:1'b0, memreq:1'b0, memwe:1'b0, done:1'b1, cc:t+2});
                halt_cyc = t + 2;
                ok = 1;
                break;
            end
            if (ins[8:5] == 4'b0001) begin
                for (int k = 0; k < MEM_LAT; k++)
                    plan.push_back('{cyc:t+2+k, pc:cur, regwr:((k == MEM_LAT-1) && !ins[4]),
                                     memreq:1'b1, memwe:ins[4], done:1'b0, cc:t+2+k});
                nxt = cur + 10'd1;
                t += 2 + MEM_LAT;
            end else if (ins[8:7] == 2'b11) begin
                if (bd_tab[cur])      nxt = cur + {2'b00, tgt_tab[cur]};
                else if (bu_tab[cur]) nxt = cur - {2'b00, tgt_tab[cur]};
                else                  nxt = cur + 10'd1;
                t += 2;
            end else begin
                plan.push_back('{cyc:t+1, pc:cur, regwr:1'b1, memreq:1'b0, memwe:1'b0, done:1'b0, cc:t+1});
                nxt = cur + 10'd1;
                t += 2;
            end
            cur = nxt;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 9'h1FF; bd_tab[i] = 0; bu_tab[i] = 0; tgt_tab[i] = '0;
        end
    endtask

    function automatic logic [8:0] rand_alu();
        logic [8:0] v;
        do v = 9'($urandom); while (v[8:7] == 2'b11 || v[8:5] == 4'b0001);
        return v;
    endfunction

    task automatic gen_random();
        int r;
        for (int i = 0; i < 1024; i++) begin
            r = $urandom_range(99, 0);
            if (r < 12)      rom[i] = 9'h1FF;
            else if (r < 27) rom[i] = {4'b0001, 1'($urandom), 4'($urandom)};
            else if (r < 50) begin
                rom[i] = {2'b11, 7'($urandom)};
                if (rom[i] == 9'h1FF) rom[i] = 9'h1FE;
            end else rom[i] = rand_alu();
            bd_tab[i]  = ($urandom_range(9, 0) < 4);
            bu_tab[i]  = ($urandom_range(9, 0) < 4);
            tgt_tab[i] = ($urandom_range(1, 0) == 0) ? 8'($urandom_range(7, 0)) : 8'($urandom);
        end
    endtask

    task automatic run_program(input bit use_ovr, input logic [8:0] ovr, input bit noise);
        bit ok;
        int halt_cyc;
        int noise_cyc;
        int base;
        if (use_ovr) rom[0] = 9'h1FF;
        build_plan(use_ovr, ovr, ok, halt_cyc);
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL plan: program does not halt, got no halt, expected halt");
            return;
        end
        foreach (plan[i]) sb.push_back(plan[i]);
        if (use_ovr) rom[0] = ovr;
        noise_cyc = (noise && halt_cyc >= 2) ? int'($urandom_range(halt_cyc - 1, 1)) : -1;
        base = done_count;
        bus.Start = 1'b1;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        for (int n = 0; n < 6000 && done_count == base; n++) begin
            bus.Start = (n == noise_cyc);
            @(posedge Clk); #1;
            if (use_ovr && n == 0) rom[0] = 9'h1FF;
        end
        bus.Start = 1'b0;
        vectors++;
        if (done_count == base) begin
            miscompares++;
            $display("FAIL run_timeout: got no Done, expected Done at cycle %0d", halt_cyc);
            Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
        end
        check("leftover_events", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        bit ok;
        int hc;
        int tries;
        clear_prog();
        bus.Start = 1'b1;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        bus.Start = 1'b0;
        check("rst_pc", bus.PC, 0);
        check("rst_ir", bus.IR, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_strobes", {bus.RegWrEn, bus.MemReq, bus.MemWe}, 0);
        check("rst_cycles", bus.CycleCount, 0);
        @(posedge Clk); #1;
        check("start_in_reset_ignored", bus.Busy, 0);
        prev_busy = bus.Busy;
        prev_done = bus.Done;
        mon_en = 1;

        // Straight line: two ALU ops then halt.
        clear_prog();
        rom[0] = 9'h005; rom[1] = 9'h0A3;
        run_program(0, 9'h0, 0);
        check("line_cycles", bus.CycleCount, 6);
        check("line_pc", bus.PC, 2);
        check("line_done", {bus.Done, bus.Busy}, 2'b10);

        // Load then store.
        clear_prog();
        rom[0] = 9'h025; rom[1] = 9'h03A;
        run_program(0, 9'h0, 1);
        check("mem_cycles", bus.CycleCount, 10);

        // Forward branch from PC 5.
        clear_prog();
        for (int i = 0; i < 5; i++) rom[i] = rand_alu();
        rom[5] = 9'h180; bd_tab[5] = 1; tgt_tab[5] = 8'd3; rom[8] = 9'h011;
        run_program(0, 9'h0, 1);
        check("br_down_pc", bus.PC, 9);

        // Backward branch from PC 5 lands on PC 2.
        clear_prog();
        rom[0] = 9'h1A0; bd_tab[0] = 1; tgt_tab[0] = 8'd5;
        rom[5] = 9'h190; bu_tab[5] = 1; tgt_tab[5] = 8'd3;
        run_program(0, 9'h0, 1);
        check("br_up_pc", bus.PC, 2);

        // Both directions asserted: forward wins.
        clear_prog();
        for (int i = 0; i < 5; i++) rom[i] = rand_alu();
        rom[5] = 9'h1C4; bd_tab[5] = 1; bu_tab[5] = 1; tgt_tab[5] = 8'd3;
        run_program(0, 9'h0, 0);
        check("br_both_pc", bus.PC, 8);

        // Backward wrap from PC 1 to 1022.
        clear_prog();
        rom[0] = 9'h044; rom[1] = 9'h181; bu_tab[1] = 1; tgt_tab[1] = 8'd3;
        run_program(0, 9'h0, 0);
        check("wrap_down_pc", bus.PC, 1022);

        // PC 0 branches back to 1023, whose ALU op wraps to 0 where a halt now sits.
        clear_prog();
        bu_tab[0] = 1; tgt_tab[0] = 8'd1; rom[1023] = 9'h077;
        run_program(1, 9'h1C0, 0);
        check("wrap_up_pc", bus.PC, 0);

        // Reset in the first memory-wait cycle.
        clear_prog();
        rom[0] = 9'h025;
        sb.push_back('{cyc:2, pc:10'd0, regwr:1'b0, memreq:1'b1, memwe:1'b0, done:1'b0, cc:2});
        bus.Start = 1'b1; @(posedge Clk); #1; bus.Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("memrst_memreq", bus.MemReq, 0);
        check("memrst_pc", bus.PC, 0);
        check("memrst_busy", {bus.Busy, bus.Done}, 0);
        check("memrst_cycles", bus.CycleCount, 0);
        check("memrst_events", sb.size(), 0);
        sb.delete();

        // Randomized programs with stray Start pulses while running.
        for (int run = 0; run < 20; run++) begin
            tries = 0;
            do begin
                gen_random();
                build_plan(0, 9'h0, ok, hc);
                tries++;
            end while (!ok && tries < 50);
            if (!ok) rom[0] = 9'h1FF;
            run_program(0, 9'h0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter PCW, default 10: program counter width.
REQ-002 Parameter W, default 8: data/target width.
REQ-003 Parameter MEM_LAT, default 2: data-memory access latency in cycles (>=1).
REQ-004 Clk  input  1  clock; all state updates on posedge.
REQ-005 Reset  input  1  synchronous, active-high.
REQ-006 Start  input  1  level; begin program at PC 0.
REQ-007 InstrIn  input  9  instruction ROM output for current PC (combinational).
REQ-008 BranchUp  input  1  decoder: taken backward branch.
REQ-009 BranchDown  input  1  decoder: taken forward branch.
REQ-010 PCTarget  input  W  decoder: branch distance, unsigned.
REQ-011 PC  output  PCW  instruction ROM address.
REQ-012 IR  output  9  latched instruction fed to decoder.
REQ-013 RegWrEn  output  1  register-file write strobe.
REQ-014 MemReq  output  1  data-memory access active.
REQ-015 MemWe  output  1  data-memory write (valid with MemReq).
REQ-016 Busy  output  1  program running.
REQ-017 Done  output  1  program halted (Ack).
REQ-018 CycleCount  output  16  cycles from Start to halt.

Function
REQ-019 FSM states: IDLE, FETCH, EXEC, MEM_WAIT, HALT.
REQ-020 IDLE: PC held 0; Start=1 -> FETCH, CycleCount cleared to 0.
REQ-021 FETCH (1 cycle): IR <= InstrIn; -> EXEC.
REQ-022 EXEC, IR==9'h1FF: -> HALT; PC unchanged; no RegWrEn.
REQ-023 EXEC, IR[8:4]==5'b00010 (lw) or 5'b00011 (sw): -> MEM_WAIT, latency counter loaded MEM_LAT-1; PC unchanged.
REQ-024 EXEC, IR[8:7]==2'b11 (branch): no RegWrEn; BranchDown -> PC+PCTarget; else BranchUp -> PC-PCTarget; else PC+1; -> FETCH.
REQ-025 EXEC, all other instructions: RegWrEn=1 for that cycle; PC+1; -> FETCH.
REQ-026 BranchDown and BranchUp both high: BranchDown wins.
REQ-027 PCTarget zero-extended to PCW; PC arithmetic modulo 2^PCW (wraps, no error).
REQ-028 MEM_WAIT: MemReq=1 every cycle; MemWe=1 iff sw; counter decrements each cycle.
REQ-029 MEM_WAIT, counter==0: RegWrEn=1 iff lw; PC+1; -> FETCH; total MEM_WAIT duration exactly MEM_LAT cycles.
REQ-030 Outside MEM_WAIT, MemReq=MemWe=0; RegWrEn asserted only per REQ-025/REQ-029.
REQ-031 HALT: Done=1, Busy=0, PC and IR held; Start=1 -> FETCH with PC=0, CycleCount cleared.
REQ-032 Start ignored in FETCH, EXEC, MEM_WAIT.
REQ-033 Busy=1 in FETCH, EXEC, MEM_WAIT; 0 in IDLE, HALT.
REQ-034 CycleCount increments each cycle while Busy; saturates at 16'hFFFF; held in HALT.
REQ-035 All outputs registered or decoded from state only; no combinational path from InstrIn to any output except via IR register.

Reset
REQ-036 Reset overrides all else, including mid-MEM_WAIT: state IDLE, PC=0, IR=0, counter=0, CycleCount=0.
REQ-037 Reset values: RegWrEn=0, MemReq=0, MemWe=0, Busy=0, Done=0.
REQ-038 Start sampled high in the Reset cycle has no effect; first possible transition is the following cycle.

Structure
REQ-039 State enum, opcode constants (LW, SW, HALT=9'h1FF, branch class 2'b11) live in shared package definitions.
REQ-040 Single module; no sub-modules; latency counter width $clog2(MEM_LAT)+1.

Verification
REQ-041 Straight-line: ROM {ALU op, ALU op, 9'h1FF}, Start pulse -> PC 0,1,2; RegWrEn pulses twice; Done=1; CycleCount=6.
REQ-042 Memory: lw at PC 0, MEM_LAT=2 -> MemReq high 2 cycles, MemWe=0, RegWrEn in 2nd; sw -> MemWe=1, no RegWrEn.
REQ-043 Branches: PC=5, BranchDown, PCTarget=3 -> PC=8; PC=5, BranchUp, PCTarget=3 -> PC=2; both high -> PC=8.
REQ-044 Wrap: PC=1023, PCW=10, non-branch -> PC=0; PC=1, BranchUp, PCTarget=3 -> PC=1022.
REQ-045 Reset in MEM_WAIT -> next cycle IDLE, MemReq=0, PC=0; Start during Busy ignored; Start in HALT restarts at PC 0.
